// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath (slave).
// The opcode and zero flag flow to the controller; enables, selects and debug state flow back.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic       branch;
  logic       pcwrite;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       zeroext;
  logic       pcen;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, branch,
           pcwrite, alusrcb, pcsrc, aluop, zeroext, pcen, illegal_op, state
  );

  modport slave (
    output op, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, branch,
           pcwrite, alusrcb, pcsrc, aluop, zeroext, pcen, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM controller for a multicycle MIPS32 datapath (lw, sw, R-type, beq, addi, j).
// Define MIPS_CTRL_ORI_EN to add ori support; otherwise ori is illegal and zeroext stays 0.
module mips_multicycle_ctrl (
  input  logic                       clk,
  input  logic                       rst,
  mips_multicycle_ctrl_if.master     bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    ORIEX   = 4'd12,
    ORIWB   = 4'd13
  } state_e;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       branch;
    logic       pcwrite;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       zeroext;
  } ctrl_t;

  state_e state_q, state_d;
  logic   illegal_op_q, illegal_op_d;
  ctrl_t  ctrl;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= FETCH;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = FETCH;
    illegal_op_d = 1'b0;
    ctrl         = '0;
    case (state_q)
      FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.pcwrite = 1'b1;
        state_d      = DECODE;
      end
      DECODE: begin
        // Branch target is computed here, speculatively, while the opcode is decoded.
        ctrl.alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MIPS_CTRL_ORI_EN
          OP_ORI:       state_d = ORIEX;
`endif
          default: begin
            state_d      = FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        state_d      = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl.iord = 1'b1;
        state_d   = MEMWB;
      end
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = 2'b10;
        state_d      = RTYPEWB;
      end
      RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = 2'b01;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        state_d      = ADDIWB;
      end
      ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      JEX: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
`ifdef MIPS_CTRL_ORI_EN
      ORIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = 2'b11;
        ctrl.zeroext = 1'b1;
        state_d      = ORIWB;
      end
      ORIWB: begin
        ctrl.regwrite = 1'b1;
      end
`endif
      default: begin
        // Unreachable encodings drive nothing and recover to FETCH.
        state_d = FETCH;
      end
    endcase
  end

  assign bus.iord       = ctrl.iord;
  assign bus.memwrite   = ctrl.memwrite;
  assign bus.irwrite    = ctrl.irwrite;
  assign bus.regdst     = ctrl.regdst;
  assign bus.memtoreg   = ctrl.memtoreg;
  assign bus.regwrite   = ctrl.regwrite;
  assign bus.alusrca    = ctrl.alusrca;
  assign bus.branch     = ctrl.branch;
  assign bus.pcwrite    = ctrl.pcwrite;
  assign bus.alusrcb    = ctrl.alusrcb;
  assign bus.pcsrc      = ctrl.pcsrc;
  assign bus.aluop      = ctrl.aluop;
  assign bus.zeroext    = ctrl.zeroext;
  assign bus.pcen       = ctrl.pcwrite | (ctrl.branch & bus.zero);
  assign bus.illegal_op = illegal_op_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-instruction path model plus directed
// literal checks for sequences, branch enable, illegal pulse and mid-instruction reset.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs per state, field order:
  // iord memwrite irwrite regdst memtoreg regwrite alusrca branch pcwrite alusrcb pcsrc aluop zeroext
  logic [15:0] exp_tab [16];
  initial begin
    for (int i = 0; i < 16; i++) exp_tab[i] = 16'h0;
    exp_tab[0]  = 16'b0_0_1_0_0_0_0_0_1_01_00_00_0;
    exp_tab[1]  = 16'b0_0_0_0_0_0_0_0_0_11_00_00_0;
    exp_tab[2]  = 16'b0_0_0_0_0_0_1_0_0_10_00_00_0;
    exp_tab[3]  = 16'b1_0_0_0_0_0_0_0_0_00_00_00_0;
    exp_tab[4]  = 16'b0_0_0_0_1_1_0_0_0_00_00_00_0;
    exp_tab[5]  = 16'b1_1_0_0_0_0_0_0_0_00_00_00_0;
    exp_tab[6]  = 16'b0_0_0_0_0_0_1_0_0_00_00_10_0;
    exp_tab[7]  = 16'b0_0_0_1_0_1_0_0_0_00_00_00_0;
    exp_tab[8]  = 16'b0_0_0_0_0_0_1_1_0_00_01_01_0;
    exp_tab[9]  = 16'b0_0_0_0_0_0_1_0_0_10_00_00_0;
    exp_tab[10] = 16'b0_0_0_0_0_1_0_0_0_00_00_00_0;
    exp_tab[11] = 16'b0_0_0_0_0_0_0_0_1_00_10_00_0;
`ifdef MIPS_CTRL_ORI_EN
    exp_tab[12] = 16'b0_0_0_0_0_0_1_0_0_10_00_11_1;
    exp_tab[13] = 16'b0_0_0_0_0_1_0_0_0_00_00_00_0;
`endif
  end

  // States visited after DECODE, as nibbles consumed LSB first; 0 ends the path at FETCH.
  function automatic logic [19:0] path_of(input logic [5:0] op);
    case (op)
      6'b100011: return 20'h00432;
      6'b101011: return 20'h00052;
      6'b000000: return 20'h00076;
      6'b000100: return 20'h00008;
      6'b001000: return 20'h000A9;
      6'b000010: return 20'h0000B;
`ifdef MIPS_CTRL_ORI_EN
      6'b001101: return 20'h000DC;
`endif
      default:   return 20'h00000;
    endcase
  endfunction

  function automatic int lat_of(input logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
`ifdef MIPS_CTRL_ORI_EN
      6'b001101: return 4;
`endif
      default:   return 2;
    endcase
  endfunction

  int          m_state = 0;
  logic [19:0] m_path  = '0;
  logic        m_ill   = 1'b0;

  always @(posedge clk) begin : model
    logic [19:0] p;
    if (!rst) begin
      m_state <= 0;
      m_path  <= '0;
      m_ill   <= 1'b0;
    end else begin
      if (m_state == 0)      p = 20'h00001;
      else if (m_state == 1) p = path_of(bus.op);
      else                   p = m_path;
      m_ill   <= (m_state == 1) && (path_of(bus.op) == 20'h0);
      m_state <= int'(p[3:0]);
      m_path  <= p >> 4;
    end
  end

  always @(negedge clk) begin : compare
    logic [15:0] act;
    logic [15:0] e;
    if (chk_en) begin
      e   = exp_tab[m_state[3:0]];
      act = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite,
             bus.alusrca, bus.branch, bus.pcwrite, bus.alusrcb, bus.pcsrc, bus.aluop, bus.zeroext};
      check("model_state", 32'(bus.state), 32'(m_state));
      check("model_ctrl", 32'(act), 32'(e));
      check("model_pcen", 32'(bus.pcen), 32'(e[7] | (e[8] & bus.zero)));
      check("model_illegal", 32'(bus.illegal_op), 32'(m_ill));
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic run_seq(input logic [5:0] o, input logic z, input logic [31:0] seq,
                         input int n, input string name);
    bus.op   = o;
    bus.zero = z;
    for (int i = 0; i < n; i++) begin
      tick();
      check(name, 32'(bus.state), 32'(seq[4*i +: 4]));
    end
  endtask

  initial begin
    rst      = 1'b0;
    bus.op   = 6'b000000;
    bus.zero = 1'b0;

    // Reset held for two cycles
    @(posedge clk);
    #1 chk_en = 1'b1;
    tick();
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_illegal", 32'(bus.illegal_op), 32'd0);
    tick();
    rst = 1'b1;

    // lw: 1,2,3,4,0 after the starting FETCH; regwrite/memtoreg only in state 4
    bus.op = 6'b100011;
    tick(); check("lw_s1", 32'(bus.state), 32'd1); check("lw_rw1", 32'(bus.regwrite), 32'd0);
    tick(); check("lw_s2", 32'(bus.state), 32'd2); check("lw_rw2", 32'(bus.regwrite), 32'd0);
    tick(); check("lw_s3", 32'(bus.state), 32'd3); check("lw_iord", 32'(bus.iord), 32'd1);
    tick(); check("lw_s4", 32'(bus.state), 32'd4);
    check("lw_rw4", 32'(bus.regwrite), 32'd1); check("lw_m2r4", 32'(bus.memtoreg), 32'd1);
    tick(); check("lw_s0", 32'(bus.state), 32'd0); check("lw_m2r0", 32'(bus.memtoreg), 32'd0);

    // beq taken / not taken
    bus.op = 6'b000100; bus.zero = 1'b1;
    tick(); tick();
    check("beq_t_state", 32'(bus.state), 32'd8); check("beq_t_pcen", 32'(bus.pcen), 32'd1);
    tick(); check("beq_t_end", 32'(bus.state), 32'd0);
    bus.zero = 1'b0;
    tick(); tick();
    check("beq_n_state", 32'(bus.state), 32'd8); check("beq_n_pcen", 32'(bus.pcen), 32'd0);
    tick(); check("beq_n_end", 32'(bus.state), 32'd0);

    // R-type
    bus.op = 6'b000000;
    tick(); check("r_s1", 32'(bus.state), 32'd1);
    tick(); check("r_s6", 32'(bus.state), 32'd6); check("r_aluop", 32'(bus.aluop), 32'd2);
    tick(); check("r_s7", 32'(bus.state), 32'd7); check("r_regdst", 32'(bus.regdst), 32'd1);
    tick(); check("r_s0", 32'(bus.state), 32'd0);

    // Unsupported opcode, then j to confirm the pulse is a single cycle
    bus.op = 6'b111111;
    tick(); check("ill_s1", 32'(bus.state), 32'd1); check("ill_pre", 32'(bus.illegal_op), 32'd0);
    tick(); check("ill_s0", 32'(bus.state), 32'd0); check("ill_pulse", 32'(bus.illegal_op), 32'd1);
    bus.op = 6'b000010;
    tick(); check("j_s1", 32'(bus.state), 32'd1); check("ill_post", 32'(bus.illegal_op), 32'd0);
    tick(); check("j_s11", 32'(bus.state), 32'd11); check("j_pcsrc", 32'(bus.pcsrc), 32'd2);
    tick(); check("j_s0", 32'(bus.state), 32'd0);

    // sw interrupted by reset in MEMWR
    bus.op = 6'b101011;
    tick(); tick(); tick();
    check("sw_s5", 32'(bus.state), 32'd5); check("sw_memwrite", 32'(bus.memwrite), 32'd1);
    rst = 1'b0;
    tick();
    check("sw_rst_state", 32'(bus.state), 32'd0); check("sw_rst_memwrite", 32'(bus.memwrite), 32'd0);
    check("sw_rst_irwrite", 32'(bus.irwrite), 32'd1);
    rst = 1'b1;

    // R-type interrupted by reset in RTYPEWB
    bus.op = 6'b000000;
    tick(); tick(); tick();
    check("rwb_s7", 32'(bus.state), 32'd7);
    rst = 1'b0;
    tick();
    check("rwb_rst_state", 32'(bus.state), 32'd0); check("rwb_rst_regwrite", 32'(bus.regwrite), 32'd0);
    rst = 1'b1;

    // Reset while DECODE sees an unsupported opcode suppresses the pulse
    bus.op = 6'b111111;
    tick(); check("illrst_s1", 32'(bus.state), 32'd1);
    rst = 1'b0;
    tick(); check("illrst_pulse", 32'(bus.illegal_op), 32'd0);
    rst = 1'b1;

    // ori
    bus.op = 6'b001101;
`ifdef MIPS_CTRL_ORI_EN
    tick(); check("ori_s1", 32'(bus.state), 32'd1);
    tick(); check("ori_s12", 32'(bus.state), 32'd12); check("ori_zext", 32'(bus.zeroext), 32'd1);
    tick(); check("ori_s13", 32'(bus.state), 32'd13); check("ori_zext_wb", 32'(bus.zeroext), 32'd0);
    tick(); check("ori_s0", 32'(bus.state), 32'd0);
`else
    tick(); check("ori_s1", 32'(bus.state), 32'd1);
    tick(); check("ori_s0", 32'(bus.state), 32'd0); check("ori_illegal", 32'(bus.illegal_op), 32'd1);
`endif

    // addi
    run_seq(6'b001000, 1'b0, 32'h00000A91, 4, "addi_seq");

    // Every opcode: FETCH-to-FETCH latency against the instruction table
    for (int o = 0; o < 64; o++) begin
      int k;
      k = 0;
      bus.op   = 6'(o);
      bus.zero = o[0];
      do begin
        tick();
        k++;
      end while (bus.state != 4'd0 && k < 8);
      check($sformatf("sweep_term_op%0d", o), 32'(bus.state), 32'd0);
      check($sformatf("latency_op%0d", o), 32'(k), 32'(lat_of(6'(o))));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; widths are fixed by the MIPS32 encoding.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 op  in  6  instruction opcode, from instruction register bits 31:26.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, branch, pcwrite  out  1 each  Moore datapath enables/selects.
REQ-007 alusrcb  out  2  ALU operand B select: 00 reg B, 01 constant 4, 10 extended immediate, 11 sign-extended immediate shifted left 2.
REQ-008 pcsrc  out  2  PC source select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 aluop  out  2  ALU decoder class: 00 add, 01 sub, 10 use funct, 11 or.
REQ-010 zeroext  out  1  1 = immediate extender zero-extends, 0 = sign-extends.
REQ-011 pcen  out  1  PC write enable = pcwrite OR (branch AND zero), combinational.
REQ-012 illegal_op  out  1  one-cycle pulse on unsupported opcode.
REQ-013 state  out  4  current FSM state, for debug and bench.

Function
REQ-014 States/encoding SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, ORIEX 12, ORIWB 13.
REQ-015 FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, pcwrite=1; next DECODE.
REQ-016 DECODE: alusrca=0, alusrcb=11, aluop=00; next by op: 100011/101011 -> MEMADR, 000000 -> RTYPEEX, 000100 -> BEQEX, 001000 -> ADDIEX, 000010 -> JEX, 001101 -> ORIEX (when enabled); any other op -> FETCH.
REQ-017 MEMADR: alusrca=1, alusrcb=10, aluop=00; next MEMRD if op=100011, else MEMWR.
REQ-018 MEMRD: iord=1; next MEMWB.  MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-019 MEMWR: iord=1, memwrite=1; next FETCH.
REQ-020 RTYPEEX: alusrca=1, alusrcb=00, aluop=10; next RTYPEWB.  RTYPEWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
REQ-021 BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; next FETCH.
REQ-022 ADDIEX: alusrca=1, alusrcb=10, aluop=00, zeroext=0; next ADDIWB.  ADDIWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
REQ-023 JEX: pcsrc=10, pcwrite=1; next FETCH.
REQ-024 Every output not listed for a state SHALL be 0 (selects 00); zeroext SHALL be 0 outside ORIEX.
REQ-025 illegal_op SHALL assert only in the cycle after DECODE sees an unsupported op (registered), exactly one cycle, while state=FETCH.
REQ-026 Instruction latencies: lw 5, sw 4, R-type 4, addi 4, ori 4, beq 3, j 3 cycles, FETCH to FETCH inclusive of FETCH.
REQ-027 Unused encodings 14-15 SHALL transition to FETCH with all outputs 0.

Reset
REQ-028 With rst=0 at a rising edge, state SHALL become FETCH and illegal_op 0, regardless of current state (including mid-instruction MEMWR or RTYPEWB).
REQ-029 During the reset cycle and after, outputs SHALL be the FETCH values (Moore); no memwrite/regwrite pulse from the aborted instruction after the reset edge.

Configuration
REQ-030 Macro MIPS_CTRL_ORI_EN: when defined, op 001101 -> ORIEX (alusrca=1, alusrcb=10, aluop=11, zeroext=1) -> ORIWB (regdst=0, memtoreg=0, regwrite=1) -> FETCH.
REQ-031 Without MIPS_CTRL_ORI_EN, op 001101 is unsupported (REQ-016/025), states 12-13 unreachable and behave as REQ-027, zeroext tied 0.

Verification
REQ-032 rst=0 two cycles, release, op=100011 -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-033 op=000100, zero=1 in BEQEX -> pcen=1 in state 8; repeat with zero=0 -> pcen=0 in state 8.
REQ-034 op=000000 -> states 0,1,6,7,0; aluop=10 in state 6, regdst=1 in state 7.
REQ-035 op=111111 -> states 0,1,0 and illegal_op=1 for exactly one cycle after DECODE.
REQ-036 op=101011, rst=0 asserted while state=5 -> next state 0, memwrite=0 after that edge.
REQ-037 op=001101 with MIPS_CTRL_ORI_EN -> states 0,1,12,13,0, zeroext=1 in state 12; without it -> illegal_op pulse.
